ps2_key_decoder: RTL
====================

# ps2_key_decoder

Parametrised PS/2 scan-code decoder between `ps2_keyboard` and display/segment logic. It pops bytes from the keyboard FIFO with a strict `ready`/`nextdata_n` handshake and tracks the E0 (extended) and F0 (break) prefixes. It maintains current-key state and a wrapping press counter, and queues decoded make/break events in a small valid/ready FIFO for downstream consumers (character renderer, seven-segment driver). It replaces ad-hoc combinational make/break tracking with one registered, verifiable block.

## Interface
- `CNT_W`, 8: press-counter width; counter wraps modulo 2^CNT_W.
- `EVT_DEPTH`, 4: event FIFO depth; power of two, ≥2.
- `REPEAT_EVT`, 0: 1 queues typematic repeat makes as events; 0 suppresses them.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `resetn`  in  1  synchronous reset, active-low.
- `ps2_data`  in  8  head byte of keyboard FIFO.
- `ps2_ready`  in  1  keyboard FIFO non-empty.
- `nextdata_n`  out  1  active-low pop strobe to keyboard FIFO; registered.
- `key_code`  out  8  code of the most recent new make.
- `key_ext`  out  1  that make carried an E0 prefix.
- `key_down`  out  1  most recent new key still held.
- `press_cnt`  out  CNT_W  count of new makes.
- `evt_valid`  out  1  event FIFO non-empty.
- `evt_data`  out  10  {ext, brk, code[7:0]} at FIFO head.
- `evt_ready`  in  1  consumer pops head when `evt_valid` is also high.
- `evt_overflow`  out  1  sticky; an event was dropped.

## Operation
- Fetch FSM has two states: FETCH and DECODE.
  - FETCH: when `ps2_ready`=1, latch `ps2_data`, drive `nextdata_n`←0, go to DECODE.
  - DECODE: `nextdata_n`←1, process the latched byte, go to FETCH.
- Prefix FSM: BASE, EXT, BRK, EXT_BRK.
  - E0: BASE→EXT, BRK→EXT_BRK. A repeated E0 keeps the current state.
  - F0: BASE→BRK, EXT→EXT_BRK. A repeated F0 keeps the current state.
  - Ignored bytes 00, AA, EE, FA, FE, FF: discarded, prefix→BASE, no event.
- Any other byte is a code. Decode it, then prefix→BASE.
  - Make is a new key when `key_down`=0, or when {ext,code} ≠ {`key_ext`,`key_code`}.
    - New key: update `key_code`/`key_ext`, set `key_down`=1, increment `press_cnt`, push event with brk=0.
    - Otherwise (typematic repeat): no counter change; push only when `REPEAT_EVT`=1.
  - Break: push event with brk=1.
    - Clear `key_down` only if {ext,code} matches the current key.
    - Releasing an older key leaves state unchanged.
- Event FIFO:
  - Push is accepted when the FIFO is not full, or when full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and `evt_overflow`←1, which holds until reset.
  - Pop occurs on `evt_valid`&&`evt_ready`. Pop on empty has no effect.
- `resetn`=0 in any cycle, including mid-handshake, returns to the reset state next edge. The latched byte is discarded and not pushed.

## Timing
- Reset values: `nextdata_n`=1, `key_code`=0, `key_ext`=0, `key_down`=0, `press_cnt`=0, `evt_valid`=0, `evt_data`=0, `evt_overflow`=0. FSMs reset to FETCH/BASE.
- Byte handshake:
  - Edge t sees `ps2_ready`=1 in FETCH.
  - Cycle t+1: `nextdata_n`=0 for exactly one cycle; keyboard FIFO advances at edge t+1.
  - Key outputs and FIFO push register at edge t+1 and are visible in cycle t+2.
  - `nextdata_n` returns to 1 in cycle t+2.
- Throughput: one byte per 2 cycles. `ps2_ready` is ignored in DECODE.
- `nextdata_n` is never low in two consecutive cycles and never low while `ps2_ready` was 0 at the preceding FETCH edge.
- No fall-through in the event FIFO: a push into an empty FIFO raises `evt_valid` one cycle after the decode edge. `evt_data` is stable while `evt_valid`=1 and no pop occurs.
- `press_cnt` at 2^CNT_W−1 plus a new make gives 0.

## Structure
- Package `ps2_pkg` holds:
  - prefix constants `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0;
  - ignored-byte constants;
  - fetch and prefix state enums;
  - `EVT_W`=10 and field offsets (`EVT_BRK`=8, `EVT_EXT`=9).
- One sub-module: `evt_fifo`, a synchronous FIFO parametrised by width/depth, with full/empty flags and registered head output.

## Test plan
- Reset, then byte 15 → `nextdata_n` low for exactly one cycle; `key_code`=15, `key_down`=1, `press_cnt`=1; event 0x015.
- Bytes E0 75, then E0 F0 75 → events 0x275 then 0x375; `key_ext`=1; `key_down` 1→0.
- 1C 1C 1C with `REPEAT_EVT`=0 → `press_cnt`=1, one event; with `REPEAT_EVT`=1 → three events.
- 1C, 32, then F0 1C → `key_code`=32, `key_down` stays 1, `press_cnt`=2.
- `evt_ready`=0, `EVT_DEPTH`=4, five makes → 4 events held, `evt_overflow`=1; at full with `evt_ready`=1 a sixth make is accepted.
- `resetn` low during DECODE of F0 → all outputs at reset values, no event; next byte 23 decodes as make 0x023.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and byte classification for the PS/2 key decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;

    localparam logic [7:0] PS2_IGN_00 = 8'h00;
    localparam logic [7:0] PS2_IGN_AA = 8'hAA;
    localparam logic [7:0] PS2_IGN_EE = 8'hEE;
    localparam logic [7:0] PS2_IGN_FA = 8'hFA;
    localparam logic [7:0] PS2_IGN_FE = 8'hFE;
    localparam logic [7:0] PS2_IGN_FF = 8'hFF;

    localparam int EVT_W   = 10;
    localparam int EVT_BRK = 8;
    localparam int EVT_EXT = 9;

    typedef enum logic {
        FETCH,
        DECODE
    } fetch_state_t;

    typedef enum logic [1:0] {
        BASE,
        EXT,
        BRK,
        EXT_BRK
    } prefix_state_t;

    // Keyboard status/ack bytes that are not key codes.
    function automatic logic is_ignored(input logic [7:0] b);
        logic ign;
        case (b)
            PS2_IGN_00, PS2_IGN_AA, PS2_IGN_EE,
            PS2_IGN_FA, PS2_IGN_FE, PS2_IGN_FF: ign = 1'b1;
            default:                            ign = 1'b0;
        endcase
        return ign;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous FIFO with a registered head word; no fall-through, so a write
// into an empty FIFO becomes visible on the following cycle.
module evt_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count;
    logic [W-1:0]  head_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = head_q;
    assign rd_next = rd_ptr + 1'b1;
    assign do_pop  = rd_en && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = wr_en && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (do_push && (empty || (count == 1 && do_pop))) begin
                head_q <= wr_data;
            end else if (do_pop && count > 1) begin
                head_q <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Pops PS/2 scan-code bytes from the keyboard FIFO, tracks E0/F0 prefixes and the
// current key, and queues make/break events for downstream display logic.
//
// state   | meaning
// --------+--------------------------------------------------------------
// FETCH   | wait for ps2_ready, latch head byte, strobe nextdata_n low
// DECODE  | release strobe, classify latched byte, update key state/event
// BASE    | no prefix pending
// EXT     | E0 seen
// BRK     | F0 seen
// EXT_BRK | E0 and F0 seen
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int EVT_DEPTH  = 4,
    parameter bit REPEAT_EVT = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic [CNT_W-1:0] press_cnt,
    output logic             evt_valid,
    output logic [EVT_W-1:0] evt_data,
    input  logic             evt_ready,
    output logic             evt_overflow
);

    fetch_state_t  fstate;
    prefix_state_t pstate;
    logic [7:0]    byte_q;

    logic             code_ext;
    logic             code_brk;
    logic             is_code;
    logic             new_make;
    logic             key_match;
    logic             push;
    logic [EVT_W-1:0] push_data;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    always_comb begin
        code_ext  = (pstate == EXT) || (pstate == EXT_BRK);
        code_brk  = (pstate == BRK) || (pstate == EXT_BRK);
        is_code   = (fstate == DECODE) && (byte_q != PS2_EXT) &&
                    (byte_q != PS2_BRK) && !is_ignored(byte_q);
        key_match = ({code_ext, byte_q} == {key_ext, key_code});
        new_make  = !key_down || !key_match;
        push      = is_code && (code_brk || new_make || REPEAT_EVT);
        push_data = '0;
        push_data[7:0]     = byte_q;
        push_data[EVT_BRK] = code_brk;
        push_data[EVT_EXT] = code_ext;
    end

    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fstate       <= FETCH;
            pstate       <= BASE;
            byte_q       <= '0;
            nextdata_n   <= 1'b1;
            key_code     <= '0;
            key_ext      <= 1'b0;
            key_down     <= 1'b0;
            press_cnt    <= '0;
            evt_overflow <= 1'b0;
        end else begin
            case (fstate)
                FETCH: begin
                    if (ps2_ready) begin
                        byte_q     <= ps2_data;
                        nextdata_n <= 1'b0;
                        fstate     <= DECODE;
                    end
                end
                DECODE: begin
                    nextdata_n <= 1'b1;
                    fstate     <= FETCH;
                    if (byte_q == PS2_EXT) begin
                        if (pstate == BASE)     pstate <= EXT;
                        else if (pstate == BRK) pstate <= EXT_BRK;
                    end else if (byte_q == PS2_BRK) begin
                        if (pstate == BASE)     pstate <= BRK;
                        else if (pstate == EXT) pstate <= EXT_BRK;
                    end else if (is_ignored(byte_q)) begin
                        pstate <= BASE;
                    end else begin
                        pstate <= BASE;
                        if (!code_brk) begin
                            if (new_make) begin
                                key_code  <= byte_q;
                                key_ext   <= code_ext;
                                key_down  <= 1'b1;
                                press_cnt <= press_cnt + 1'b1;
                            end
                        end else if (key_match) begin
                            // Releasing an older key leaves the current key held.
                            key_down <= 1'b0;
                        end
                    end
                end
                default: fstate <= FETCH;
            endcase
            if (push && fifo_full && !pop) begin
                evt_overflow <= 1'b1;
            end
        end
    end

    evt_fifo #(
        .W     (EVT_W),
        .DEPTH (EVT_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (evt_ready),
        .rd_data (evt_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
